// File: rtl/sb_tx_credit_arbiter.sv
// sb_tx_credit_arbiter
// Sideband TX arbiter that merges adapter (D2D) and PHY messages into the
// shared sideband TX FIFO. Each granted message is written as two FIFO words:
// the header, then the data word (zero when the message carries no data).
// Adapter messages are gated by a credit counter that the credit notifier
// refills one credit per i_pl_cfg_crd pulse.
//
// Build option:
//   SB_PHY_PRIORITY_EN - when defined, PHY always wins a contested IDLE cycle
//                        and no round-robin pointer is built. When undefined,
//                        the two sources alternate (round-robin, adapter first
//                        after reset).
module sb_tx_credit_arbiter #(
  parameter int INIT_CREDITS = 32,
  parameter int CRD_W        = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pl_cfg_crd,
  input  logic             i_adp_req,
  input  logic             i_adp_has_data,
  input  logic [63:0]      i_adp_hdr,
  input  logic [63:0]      i_adp_data,
  input  logic             i_phy_req,
  input  logic             i_phy_has_data,
  input  logic [63:0]      i_phy_hdr,
  input  logic [63:0]      i_phy_data,
  input  logic             i_fifo_room,
  output logic             o_adp_gnt,
  output logic             o_phy_gnt,
  output logic             o_fifo_wr_en,
  output logic [63:0]      o_fifo_wdata,
  output logic [CRD_W-1:0] o_credit_cnt,
  output logic             o_credit_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_HDR  = 2'd1,
    WR_DATA = 2'd2
  } state_e;

  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(INIT_CREDITS);
  localparam logic [CRD_W-1:0] CRD_ONE = CRD_W'(1);

  state_e            state_q, state_d;
  logic [63:0]       dataLatch_q, dataLatch_d;
  logic              adpGnt_q, adpGnt_d;
  logic              phyGnt_q, phyGnt_d;
  logic              wrEn_q, wrEn_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [CRD_W-1:0]  credit_q, credit_d;
  logic              creditErr_q, creditErr_d;
`ifndef SB_PHY_PRIORITY_EN
  logic              rrAdp_q, rrAdp_d;
`endif

  logic              adpElig;
  logic              phyElig;
  logic              selAdp;
  logic              selPhy;

  // Pick a winner in IDLE when the FIFO can take a whole message; the adapter
  // only competes while it still holds at least one credit.
  always_comb begin
    adpElig = i_adp_req && (credit_q != '0);
    phyElig = i_phy_req;
    selAdp  = 1'b0;
    selPhy  = 1'b0;
    if ((state_q == IDLE) && i_fifo_room) begin
      if (adpElig && phyElig) begin
`ifdef SB_PHY_PRIORITY_EN
        selPhy = 1'b1;
`else
        if (rrAdp_q) begin
          selAdp = 1'b1;
        end else begin
          selPhy = 1'b1;
        end
`endif
      end else if (adpElig) begin
        selAdp = 1'b1;
      end else if (phyElig) begin
        selPhy = 1'b1;
      end
    end
  end

  // Message sequencer: the selection cycle preloads the header word and the
  // grant pulse so every output comes straight from a flop; WR_HDR then
  // queues the latched data word and WR_DATA closes out the message.
  always_comb begin
    state_d     = state_q;
    dataLatch_d = dataLatch_q;
    adpGnt_d    = 1'b0;
    phyGnt_d    = 1'b0;
    wrEn_d      = 1'b0;
    wdata_d     = 64'h0;
`ifndef SB_PHY_PRIORITY_EN
    rrAdp_d     = rrAdp_q;
`endif
    case (state_q)
      IDLE: begin
        if (selAdp) begin
          state_d     = WR_HDR;
          adpGnt_d    = 1'b1;
          wrEn_d      = 1'b1;
          wdata_d     = i_adp_hdr;
          dataLatch_d = i_adp_has_data ? i_adp_data : 64'h0;
`ifndef SB_PHY_PRIORITY_EN
          rrAdp_d     = 1'b0;
`endif
        end else if (selPhy) begin
          state_d     = WR_HDR;
          phyGnt_d    = 1'b1;
          wrEn_d      = 1'b1;
          wdata_d     = i_phy_hdr;
          dataLatch_d = i_phy_has_data ? i_phy_data : 64'h0;
`ifndef SB_PHY_PRIORITY_EN
          rrAdp_d     = 1'b1;
`endif
        end
      end
      WR_HDR: begin
        state_d = WR_DATA;
        wrEn_d  = 1'b1;
        wdata_d = dataLatch_q;
      end
      WR_DATA: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Credit bookkeeping: a selection and a return in the same cycle cancel,
  // and a return that would exceed the initial allotment is dropped and
  // flagged as a sticky protocol error.
  always_comb begin
    credit_d    = credit_q;
    creditErr_d = creditErr_q;
    if (selAdp && !i_pl_cfg_crd) begin
      credit_d = credit_q - CRD_ONE;
    end else if (!selAdp && i_pl_cfg_crd) begin
      if (credit_q == CRD_MAX) begin
        creditErr_d = 1'b1;
      end else begin
        credit_d = credit_q + CRD_ONE;
      end
    end
  end

  // State, latched data, outputs and credits; reset aborts any message.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      dataLatch_q <= 64'h0;
      adpGnt_q    <= 1'b0;
      phyGnt_q    <= 1'b0;
      wrEn_q      <= 1'b0;
      wdata_q     <= 64'h0;
      credit_q    <= CRD_MAX;
      creditErr_q <= 1'b0;
`ifndef SB_PHY_PRIORITY_EN
      rrAdp_q     <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      dataLatch_q <= dataLatch_d;
      adpGnt_q    <= adpGnt_d;
      phyGnt_q    <= phyGnt_d;
      wrEn_q      <= wrEn_d;
      wdata_q     <= wdata_d;
      credit_q    <= credit_d;
      creditErr_q <= creditErr_d;
`ifndef SB_PHY_PRIORITY_EN
      rrAdp_q     <= rrAdp_d;
`endif
    end
  end

  assign o_adp_gnt    = adpGnt_q;
  assign o_phy_gnt    = phyGnt_q;
  assign o_fifo_wr_en = wrEn_q;
  assign o_fifo_wdata = wdata_q;
  assign o_credit_cnt = credit_q;
  assign o_credit_err = creditErr_q;

endmodule

// File: tb/tb_sb_tx_credit_arbiter.sv
// tb_sb_tx_credit_arbiter
// Directed bench for sb_tx_credit_arbiter. Expected values are hand-derived
// from the arbiter's timing: selection at an IDLE edge shows the grant and
// header write right after that edge, the data write one cycle later, and
// IDLE again the cycle after that. Honours SB_PHY_PRIORITY_EN for the
// contested-arbitration expectations.
module tb_sb_tx_credit_arbiter;

  logic        clk;
  logic        rstN;
  logic        plCfgCrd;
  logic        adpReq;
  logic        adpHasData;
  logic [63:0] adpHdr;
  logic [63:0] adpData;
  logic        phyReq;
  logic        phyHasData;
  logic [63:0] phyHdr;
  logic [63:0] phyData;
  logic        fifoRoom;
  logic        adpGnt;
  logic        phyGnt;
  logic        fifoWrEn;
  logic [63:0] fifoWdata;
  logic [5:0]  creditCnt;
  logic        creditErr;

  int errors = 0;
  int checks = 0;
  logic expAdp;

  sb_tx_credit_arbiter #(
    .INIT_CREDITS(32),
    .CRD_W       (6)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_pl_cfg_crd  (plCfgCrd),
    .i_adp_req     (adpReq),
    .i_adp_has_data(adpHasData),
    .i_adp_hdr     (adpHdr),
    .i_adp_data    (adpData),
    .i_phy_req     (phyReq),
    .i_phy_has_data(phyHasData),
    .i_phy_hdr     (phyHdr),
    .i_phy_data    (phyData),
    .i_fifo_room   (fifoRoom),
    .o_adp_gnt     (adpGnt),
    .o_phy_gnt     (phyGnt),
    .o_fifo_wr_en  (fifoWrEn),
    .o_fifo_wdata  (fifoWdata),
    .o_credit_cnt  (creditCnt),
    .o_credit_err  (creditErr)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive both message sources at once.
  task automatic applyStimulus(input logic aReq, input logic aHasData,
                               input logic [63:0] aHdr, input logic [63:0] aData,
                               input logic pReq, input logic pHasData,
                               input logic [63:0] pHdr, input logic [63:0] pData);
    adpReq     = aReq;
    adpHasData = aHasData;
    adpHdr     = aHdr;
    adpData    = aData;
    phyReq     = pReq;
    phyHasData = pHasData;
    phyHdr     = pHdr;
    phyData    = pData;
  endtask

  // One comparison: counts it and reports a failure with observed/expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Synchronous-looking reset pulse with quiet inputs; ends in IDLE.
  task automatic doReset();
    @(negedge clk);
    rstN     = 1'b0;
    plCfgCrd = 1'b0;
    fifoRoom = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    cycle();
  endtask

  initial begin
    rstN     = 1'b0;
    plCfgCrd = 1'b0;
    fifoRoom = 1'b1;
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);

    // Reset values
    @(negedge clk);
    checkOutput("rst_adp_gnt", adpGnt, 1'b0);
    checkOutput("rst_phy_gnt", phyGnt, 1'b0);
    checkOutput("rst_wr_en", fifoWrEn, 1'b0);
    checkOutput("rst_wdata", fifoWdata, 64'h0);
    checkOutput("rst_cnt", creditCnt, 32);
    checkOutput("rst_err", creditErr, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    cycle();

    // Adapter message with data
    applyStimulus(1'b1, 1'b1, 64'hA5A5, 64'h1234, 1'b0, 1'b0, 64'h0, 64'h0);
    cycle();
    checkOutput("t1_adp_gnt", adpGnt, 1'b1);
    checkOutput("t1_phy_gnt", phyGnt, 1'b0);
    checkOutput("t1_hdr_wr", fifoWrEn, 1'b1);
    checkOutput("t1_hdr", fifoWdata, 64'hA5A5);
    checkOutput("t1_cnt", creditCnt, 31);
    adpReq = 1'b0;
    cycle();
    checkOutput("t1_gnt_pulse", adpGnt, 1'b0);
    checkOutput("t1_data_wr", fifoWrEn, 1'b1);
    checkOutput("t1_data", fifoWdata, 64'h1234);
    cycle();
    checkOutput("t1_idle_wr", fifoWrEn, 1'b0);
    checkOutput("t1_idle_wdata", fifoWdata, 64'h0);

    // Adapter message without data
    applyStimulus(1'b1, 1'b0, 64'h55, 64'hDEAD, 1'b0, 1'b0, 64'h0, 64'h0);
    cycle();
    checkOutput("t2_adp_gnt", adpGnt, 1'b1);
    checkOutput("t2_hdr", fifoWdata, 64'h55);
    checkOutput("t2_cnt", creditCnt, 30);
    adpReq = 1'b0;
    cycle();
    checkOutput("t2_data_wr", fifoWrEn, 1'b1);
    checkOutput("t2_data_zero", fifoWdata, 64'h0);
    cycle();
    checkOutput("t2_idle_wr", fifoWrEn, 1'b0);

    // Both sources requesting continuously
    doReset();
    applyStimulus(1'b1, 1'b1, 64'hAD0, 64'hAD1, 1'b1, 1'b1, 64'hF00, 64'hF01);
    for (int k = 0; k < 4; k++) begin
`ifdef SB_PHY_PRIORITY_EN
      expAdp = 1'b0;
`else
      expAdp = ((k % 2) == 0);
`endif
      cycle();
      checkOutput("rr_adp_gnt", adpGnt, expAdp);
      checkOutput("rr_phy_gnt", phyGnt, !expAdp);
      checkOutput("rr_hdr", fifoWdata, expAdp ? 64'hAD0 : 64'hF00);
      cycle();
      checkOutput("rr_data", fifoWdata, expAdp ? 64'hAD1 : 64'hF01);
      cycle();
      checkOutput("rr_idle_wr", fifoWrEn, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
`ifdef SB_PHY_PRIORITY_EN
    checkOutput("rr_cnt", creditCnt, 32);
`else
    checkOutput("rr_cnt", creditCnt, 30);
`endif

    // Drain all credits with 32 adapter messages
    doReset();
    applyStimulus(1'b1, 1'b1, 64'hC0, 64'hC1, 1'b0, 1'b0, 64'h0, 64'h0);
    for (int i = 0; i < 32; i++) begin
      cycle();
      checkOutput("drain_gnt", adpGnt, 1'b1);
      checkOutput("drain_cnt", creditCnt, 31 - i);
      cycle();
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput("starve_adp_gnt", adpGnt, 1'b0);
      checkOutput("starve_wr_en", fifoWrEn, 1'b0);
    end
    phyReq     = 1'b1;
    phyHasData = 1'b1;
    phyHdr     = 64'hB0;
    phyData    = 64'hB1;
    cycle();
    checkOutput("starve_phy_gnt", phyGnt, 1'b1);
    checkOutput("starve_phy_hdr", fifoWdata, 64'hB0);
    checkOutput("starve_adp_gnt2", adpGnt, 1'b0);
    phyReq = 1'b0;
    cycle();
    cycle();
    cycle();
    checkOutput("starve_adp_gnt3", adpGnt, 1'b0);
    plCfgCrd = 1'b1;
    cycle();
    plCfgCrd = 1'b0;
    checkOutput("refill_cnt", creditCnt, 1);
    checkOutput("refill_no_gnt_yet", adpGnt, 1'b0);
    cycle();
    checkOutput("refill_adp_gnt", adpGnt, 1'b1);
    checkOutput("refill_cnt_zero", creditCnt, 0);
    adpReq = 1'b0;
    cycle();
    cycle();

    // Credit return coinciding with an adapter selection
    plCfgCrd = 1'b1;
    cycle();
    checkOutput("same_pre_cnt", creditCnt, 1);
    adpReq = 1'b1;
    cycle();
    plCfgCrd = 1'b0;
    adpReq   = 1'b0;
    checkOutput("same_adp_gnt", adpGnt, 1'b1);
    checkOutput("same_cnt", creditCnt, 1);
    cycle();
    cycle();

    // Credit return while already full
    doReset();
    plCfgCrd = 1'b1;
    cycle();
    plCfgCrd = 1'b0;
    checkOutput("ovf_cnt", creditCnt, 32);
    checkOutput("ovf_err", creditErr, 1'b1);
    cycle();
    checkOutput("ovf_err_sticky", creditErr, 1'b1);

    // FIFO full holds off arbitration
    fifoRoom = 1'b0;
    applyStimulus(1'b1, 1'b1, 64'hE0, 64'hE1, 1'b1, 1'b1, 64'hE8, 64'hE9);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkOutput("full_adp_gnt", adpGnt, 1'b0);
      checkOutput("full_phy_gnt", phyGnt, 1'b0);
      checkOutput("full_wr_en", fifoWrEn, 1'b0);
    end
    fifoRoom = 1'b1;
    cycle();
`ifdef SB_PHY_PRIORITY_EN
    expAdp = 1'b0;
`else
    expAdp = 1'b1;
`endif
    checkOutput("room_adp_gnt", adpGnt, expAdp);
    checkOutput("room_phy_gnt", phyGnt, !expAdp);
    checkOutput("room_wr_en", fifoWrEn, 1'b1);
    applyStimulus(1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    cycle();
    cycle();

    // Reset during the header write
    applyStimulus(1'b1, 1'b1, 64'h77, 64'h78, 1'b0, 1'b0, 64'h0, 64'h0);
    cycle();
    checkOutput("mid_hdr_wr", fifoWrEn, 1'b1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("mid_rst_wr_en", fifoWrEn, 1'b0);
    checkOutput("mid_rst_wdata", fifoWdata, 64'h0);
    checkOutput("mid_rst_gnt", adpGnt, 1'b0);
    checkOutput("mid_rst_cnt", creditCnt, 32);
    #2;
    rstN = 1'b1;
    cycle();
    checkOutput("post_rst_gnt", adpGnt, 1'b1);
    checkOutput("post_rst_hdr", fifoWdata, 64'h77);
    checkOutput("post_rst_cnt", creditCnt, 31);
    adpReq = 1'b0;
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sb_tx_credit_arbiter.md
# sb_tx_credit_arbiter

Sideband TX arbiter between the adapter (D2D) and PHY message sources and the shared sideband TX FIFO. Adapter config messages are gated by a credit counter, which is replenished by the one-cycle credit-return pulse that the credit notifier raises each time an adapter message drains from the FIFO. Every granted message occupies exactly two FIFO words: a 64-bit header, then 64-bit data (or 64'b0 for messages without data).

## Interface
- INIT_CREDITS, 32: credit count loaded at reset; also the saturation ceiling.
- CRD_W, 6: credit counter width; must satisfy 2^CRD_W > INIT_CREDITS.
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_pl_cfg_crd  in  1  credit-return pulse, +1 credit per high cycle
- i_adp_req  in  1  adapter message pending; hdr/data/has_data held stable while high
- i_adp_has_data  in  1  adapter message carries data
- i_adp_hdr  in  64  adapter header
- i_adp_data  in  64  adapter data
- i_phy_req, i_phy_has_data  in  1 each  PHY equivalents
- i_phy_hdr, i_phy_data  in  64 each  PHY equivalents
- i_fifo_room  in  1  FIFO has at least 2 free entries
- o_adp_gnt  out  1  one-cycle grant pulse to adapter
- o_phy_gnt  out  1  one-cycle grant pulse to PHY
- o_fifo_wr_en  out  1  FIFO write strobe
- o_fifo_wdata  out  64  FIFO write data
- o_credit_cnt  out  CRD_W  current adapter credits
- o_credit_err  out  1  sticky flag: credit returned while at INIT_CREDITS

## Operation
- FSM states: IDLE, WR_HDR, WR_DATA.
- IDLE:
  - Adapter is eligible when i_adp_req=1 and o_credit_cnt!=0.
  - PHY is eligible when i_phy_req=1.
  - When i_fifo_room=1 and at least one source is eligible, select a winner.
  - On selection: latch its hdr, its data (or 64'b0 if has_data=0), and its identity; go to WR_HDR.
  - Otherwise remain in IDLE.
- WR_HDR: o_fifo_wr_en=1, o_fifo_wdata=latched hdr; go to WR_DATA.
- WR_DATA: o_fifo_wr_en=1, o_fifo_wdata=latched data/zeros; go to IDLE.
- Arbitration with both sources eligible: round-robin. The pointer flips to the other source after each grant. At reset the pointer favours the adapter.
- Credits:
  - Decrement by 1 on each adapter selection.
  - Increment by 1 on each i_pl_cfg_crd cycle.
  - Decrement and return in the same cycle: count unchanged.
  - Return while count==INIT_CREDITS with no decrement: count holds and o_credit_err sets; it clears only on reset.
  - The count never goes below 0, because the adapter is ineligible at 0.
- PHY messages consume no credits.
- i_fifo_room is sampled only in IDLE. Both writes of a message always complete once it is selected.
- o_fifo_wdata is 0 whenever o_fifo_wr_en=0.

## Timing
- All outputs are registered.
- Reset values:
  - o_adp_gnt, o_phy_gnt, o_fifo_wr_en, o_credit_err: 0.
  - o_fifo_wdata: 0.
  - o_credit_cnt: INIT_CREDITS.
  - FSM: IDLE; round-robin pointer: adapter.
- Selection in IDLE at cycle N produces:
  - the grant pulse in cycle N+1, concurrent with the header write;
  - the data write in cycle N+2;
  - a return to IDLE in cycle N+3.
- Peak throughput is one message per 3 cycles.
- A requester drops req in the grant cycle if it has no further message. req is re-sampled only in IDLE, so a req still held at N+3 counts as a new message.
- o_credit_cnt updates in the cycle after a selection or after an i_pl_cfg_crd pulse.
- Reset asserted mid-message aborts the message; partial FIFO content is the FIFO owner's concern.

## Configuration
- SB_PHY_PRIORITY_EN defined: the PHY always wins when both sources are eligible. The round-robin pointer is not implemented.
- SB_PHY_PRIORITY_EN undefined: round-robin as described above.

## Test plan
- Reset, then adapter-only message with has_data=1 (hdr=0xA5A5, data=0x1234):
  - o_adp_gnt at N+1;
  - writes 0xA5A5 then 0x1234;
  - o_credit_cnt goes 32→31.
- Adapter message with has_data=0: second write is 64'h0; 1 credit consumed.
- Both sources requesting continuously:
  - without the macro, grants alternate adapter, PHY, adapter…;
  - with SB_PHY_PRIORITY_EN, every grant goes to PHY.
- Drain credits to 0 with 32 adapter messages:
  - the 33rd adapter req gets no grant;
  - a PHY req is still granted;
  - one i_pl_cfg_crd pulse lets the adapter be granted, and the count returns to 0 after that grant.
- Credit return in the same cycle as an adapter selection: o_credit_cnt unchanged.
- Return at count=32: o_credit_err=1, count stays 32.
- i_fifo_room=0 with requests pending: no grants and no writes. Assert room: grant follows in the next cycle.
- Assert reset during WR_HDR:
  - o_fifo_wr_en=0 immediately;
  - count back to 32;
  - FSM in IDLE.
